// File: rtl/ack_gen_q.sv
`default_nettype none
// ============================================================================
//  Module   : ack_gen_q
//  Purpose  : In-order acknowledge generator for peripheral bus slaves.
//             Holds up to DEPTH outstanding read/write requests, each with
//             its own latency (per-direction base + runtime wait states).
//             Every entry counts down concurrently, but acks are released
//             strictly in request order from the queue head.
//
//  Ports    : clk_i        clock, rising edge
//             rst_i        synchronous active-high reset (flushes queue)
//             ce_i         clock enable; low freezes all state
//             req_i        request strobe
//             we_i         request direction, 1 = write
//             id_i         request ID
//             wait_i       extra wait states for this request (0-15)
//             ready_o      queue can accept (count_o < DEPTH)
//             ack_o        acknowledge, active level is ~ACK_LEVEL
//             ack_we_o     direction of the acked request (0 when idle)
//             ack_id_o     ID of the acked request (0 when idle)
//             ack_ready_i  consumer accepts ack (hold build only)
//             count_o      number of outstanding entries (0..DEPTH)
//             ovf_o        sticky: a request was dropped while full
//
//  Build option : define ACK_GEN_Q_HOLD_EN to hold the head ack until
//                 ack_ready_i is high. Without it the ack is a one
//                 ce-cycle pulse and ack_ready_i is ignored.
//
//  Revision : 1.0  initial release
// ============================================================================
module ack_gen_q #(
   parameter int   ID_W          = 4,
   parameter int   DEPTH         = 4,
   parameter int   READ_STAGES   = 3,
   parameter int   WRITE_STAGES  = 1,
   parameter logic ACK_LEVEL     = 1'b0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       ce_i,
   input  logic                       req_i,
   input  logic                       we_i,
   input  logic [ID_W-1:0]            id_i,
   input  logic [3:0]                 wait_i,
   output logic                       ready_o,
   output logic                       ack_o,
   output logic                       ack_we_o,
   output logic [ID_W-1:0]            ack_id_o,
   input  logic                       ack_ready_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       ovf_o
);

   localparam int c_PTR_W    = $clog2(DEPTH);
   localparam int c_CNT_W    = c_PTR_W + 1;
   localparam int c_MAX_ST   = (READ_STAGES > WRITE_STAGES) ? READ_STAGES : WRITE_STAGES;
   // Wide enough for the largest base latency plus 15 wait states.
   localparam int c_LAT_RAW  = $clog2(c_MAX_ST + 16);
   localparam int c_LAT_W    = (c_LAT_RAW > 5) ? c_LAT_RAW : 5;

   localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);
   localparam logic [c_LAT_W-1:0] c_RD_BASE  = c_LAT_W'(READ_STAGES);
   localparam logic [c_LAT_W-1:0] c_WR_BASE  = c_LAT_W'(WRITE_STAGES);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

   // Queue storage
   logic               r_valid [DEPTH];
   logic               r_we    [DEPTH];
   logic [ID_W-1:0]    r_id    [DEPTH];
   logic [c_LAT_W-1:0] r_cnt   [DEPTH];

   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               r_ovf;

   logic               w_ready;
   logic               w_acc;
   logic               w_pop;
   logic               w_ack_act;
   logic [c_LAT_W-1:0] w_lat;
   logic [c_LAT_W-1:0] w_load;

   // ------------------------------------------------------------------
   // Request side
   // ------------------------------------------------------------------
   assign w_ready = (r_count != c_CNT_FULL);
   assign w_acc   = ce_i & req_i & w_ready;

   assign w_lat   = (we_i ? c_WR_BASE : c_RD_BASE)
                  + {{(c_LAT_W-4){1'b0}}, wait_i};
   // A zero latency still needs one cycle to present the ack.
   assign w_load  = (w_lat == '0) ? '0 : (w_lat - c_LAT_ONE);

   // ------------------------------------------------------------------
   // Head / ack side
   // ------------------------------------------------------------------
   assign w_ack_act = r_valid[r_rd_ptr] & (r_cnt[r_rd_ptr] == '0);

`ifdef ACK_GEN_Q_HOLD_EN
   assign w_pop = ce_i & w_ack_act & ack_ready_i;
`else
   assign w_pop = ce_i & w_ack_act;
   logic w_unused_ack_ready;
   assign w_unused_ack_ready = ack_ready_i;
`endif

   // ------------------------------------------------------------------
   // Per-entry storage and timers. All valid entries count down
   // together so that a younger entry already expired acks immediately
   // after the head pops.
   // ------------------------------------------------------------------
   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      localparam logic [c_PTR_W-1:0] c_IDX = c_PTR_W'(g);

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_valid[g] <= 1'b0;
            r_we[g]    <= 1'b0;
            r_id[g]    <= '0;
            r_cnt[g]   <= '0;
         end else if (ce_i) begin
            if (w_acc && (r_wr_ptr == c_IDX)) begin
               // Write slot is never the slot being popped: it is free.
               r_valid[g] <= 1'b1;
               r_we[g]    <= we_i;
               r_id[g]    <= id_i;
               r_cnt[g]   <= w_load;
            end else begin
               if (w_pop && (r_rd_ptr == c_IDX)) begin
                  r_valid[g] <= 1'b0;
               end
               if (r_valid[g] && (r_cnt[g] != '0)) begin
                  r_cnt[g] <= r_cnt[g] - c_LAT_ONE;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Pointers, occupancy, overflow flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else if (ce_i) begin
         if (w_acc) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_acc, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (req_i && !w_ready) begin
            r_ovf <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs: purely from registered state
   // ------------------------------------------------------------------
   always_comb begin
      ack_o    = ACK_LEVEL;
      ack_we_o = 1'b0;
      ack_id_o = '0;
      if (w_ack_act) begin
         ack_o    = ~ACK_LEVEL;
         ack_we_o = r_we[r_rd_ptr];
         ack_id_o = r_id[r_rd_ptr];
      end
   end

   assign ready_o = w_ready;
   assign count_o = r_count;
   assign ovf_o   = r_ovf;

endmodule
`default_nettype wire
